// File: rtl/spw_clkgen_pkg.sv
// -----------------------------------------------------------------------------
// spw_clkgen_pkg
// Shared constants for the SpaceWire clock-enable divider generator:
// default parameter values, the supported channel range and a helper that
// sizes the channel-select field.
// -----------------------------------------------------------------------------
package spw_clkgen_pkg;

  localparam int MAX_CH          = 16;
  localparam int DEF_NUM_CH      = 5;
  localparam int DEF_DIV_W       = 8;
  localparam int DEF_DIV_INIT    = 9;
  localparam int DEF_LOCK_CYCLES = 16;

  // Width of a channel index; one bit minimum so a single-channel build
  // still has a usable select port.
  function automatic int ch_sel_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/spw_clkgen_ch.sv
// -----------------------------------------------------------------------------
// spw_clkgen_ch
// One divider channel: period counter, shadow/active divisor pair and the
// registered clken / outclk outputs.
//
// Ports
//   refclk     in   sole clock, rising edge
//   rst        in   synchronous active-high reset
//   locked     in   generator lock; counter held at 0 and outputs forced low
//                   while deasserted
//   wr         in   write strobe already decoded for this channel
//   wr_val     in   divisor D captured into the shadow register on wr
//   sync_apply in   global update instant (used only when
//                   SPW_CLKGEN_SYNC_UPDATE_EN is defined)
//   wrap       out  combinational: counter == active divisor this cycle
//   clken      out  one-cycle enable pulse, registered from wrap
//   outclk     out  registered divided clock, high for ceil((D+1)/2) cycles
//   pending    out  shadow holds a divisor not yet applied
// -----------------------------------------------------------------------------
module spw_clkgen_ch
  import spw_clkgen_pkg::*;
#(
  parameter int DIV_W    = DEF_DIV_W,
  parameter int DIV_INIT = DEF_DIV_INIT
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             locked,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_val,
  input  logic             sync_apply,
  output logic             wrap,
  output logic             clken,
  output logic             outclk,
  output logic             pending
);

  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DIV_INIT);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] active_div;
  logic [DIV_W-1:0] shadow_div;
  logic             apply;
  logic             restart;
  logic [DIV_W:0]   high_len;
  logic             high_phase;

  // Gated by locked so nothing wraps (or updates) during the lock window.
  assign wrap = locked && (cnt == active_div);

`ifdef SPW_CLKGEN_SYNC_UPDATE_EN
  // Updates land together at channel 0's wrap; every counter restarts then
  // so all channels come out of the update phase-aligned.
  assign apply   = sync_apply && pending;
  assign restart = sync_apply;
`else
  // Swapping only at the own wrap keeps every period whole.
  assign apply   = wrap && pending;
  assign restart = 1'b0;
  logic unused_sync;
  assign unused_sync = sync_apply;
`endif

  // ceil(P/2) with P = D+1; one extra bit so D = all-ones cannot overflow.
  assign high_len   = ({1'b0, active_div} + (DIV_W+1)'(2)) >> 1;
  assign high_phase = ({1'b0, cnt} < high_len);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge refclk) begin
    if (rst) begin
      // NOTE: the divisor registers are plain flops, not a RAM, so they are
      // reset explicitly to give a known period immediately after lock.
      cnt        <= '0;
      active_div <= DIV_RST;
      shadow_div <= DIV_RST;
      pending    <= 1'b0;
      clken      <= 1'b0;
      outclk     <= 1'b0;
    end else begin
      if (!locked || wrap || restart) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end

      if (apply) begin
        active_div <= shadow_div;
        pending    <= 1'b0;
      end

      // Placed after the apply so a write landing on the update instant
      // keeps pending set; the freshly written value waits for the next one.
      if (wr) begin
        shadow_div <= wr_val;
        pending    <= 1'b1;
      end

      clken  <= wrap;
      outclk <= locked && high_phase;
    end
  end

endmodule

// File: rtl/spw_clken_divgen.sv
// -----------------------------------------------------------------------------
// spw_clken_divgen
// Multi-channel clock-enable / divided-clock generator. Each channel divides
// refclk by D+1. After reset a lock counter runs LOCK_CYCLES cycles; until
// then all outputs are low and every channel counter is held at 0, so all
// channels start phase-aligned when locked rises. Divisor writes go to a
// per-channel shadow register and take effect on a period boundary.
//
// Build option
//   SPW_CLKGEN_SYNC_UPDATE_EN  defined:   all pending divisors are applied
//                                         together at channel 0's wrap and
//                                         every channel counter restarts
//                              undefined: each channel applies at its own wrap
//
// Parameters
//   NUM_CH       number of channels (1..16)
//   DIV_W        divisor width
//   DIV_INIT     divisor loaded into every channel on reset
//   LOCK_CYCLES  cycles from reset release until locked (>= 1)
//
// Ports
//   refclk   in   sole clock, rising edge
//   rst      in   synchronous active-high reset
//   div_wr   in   single-cycle divisor write strobe
//   div_ch   in   target channel; values >= NUM_CH are ignored
//   div_val  in   new divisor D
//   clken    out  per-channel one-cycle enable pulse, every D+1 cycles
//   outclk   out  per-channel registered divided clock
//   pending  out  per-channel divisor update waiting to be applied
//   locked   out  outputs valid
// -----------------------------------------------------------------------------
module spw_clken_divgen
  import spw_clkgen_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int DIV_W       = DEF_DIV_W,
  parameter int DIV_INIT    = DEF_DIV_INIT,
  parameter int LOCK_CYCLES = DEF_LOCK_CYCLES
) (
  input  logic                              refclk,
  input  logic                              rst,
  input  logic                              div_wr,
  input  logic [ch_sel_width(NUM_CH)-1:0]   div_ch,
  input  logic [DIV_W-1:0]                  div_val,
  output logic [NUM_CH-1:0]                 clken,
  output logic [NUM_CH-1:0]                 outclk,
  output logic [NUM_CH-1:0]                 pending,
  output logic                              locked
);

  localparam int                CH_W      = ch_sel_width(NUM_CH);
  localparam int                LOCK_W    = $clog2(LOCK_CYCLES + 1);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);

  logic [LOCK_W-1:0] lock_cnt;
  logic [NUM_CH-1:0] wr_sel;
  logic [NUM_CH-1:0] wrap;
  logic              sync_apply;
  logic              unused_wrap;

  // Lock sequence: counts cycles since reset release and freezes once
  // locked, so only rst can drop it again.
  always_ff @(posedge refclk) begin
    if (rst) begin
      lock_cnt <= '0;
      locked   <= 1'b0;
    end else if (!locked) begin
      lock_cnt <= lock_cnt + 1'b1;
      if (lock_cnt == LOCK_LAST) begin
        locked <= 1'b1;
      end
    end
  end

  // Write decode; an out-of-range div_ch matches no channel.
  always_comb begin
    // NOTE: default first so every path assigns wr_sel and no latch forms.
    wr_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_sel[i] = div_wr && (div_ch == CH_W'(i));
    end
  end

`ifdef SPW_CLKGEN_SYNC_UPDATE_EN
  assign sync_apply = wrap[0] && (|pending);
`else
  assign sync_apply = 1'b0;
`endif

  // Only channel 0's wrap can feed the global update; the other bits exist
  // because every channel is the same module.
  assign unused_wrap = ^wrap;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    spw_clkgen_ch #(
      .DIV_W    (DIV_W),
      .DIV_INIT (DIV_INIT)
    ) u_ch (
      .refclk     (refclk),
      .rst        (rst),
      .locked     (locked),
      .wr         (wr_sel[i]),
      .wr_val     (div_val),
      .sync_apply (sync_apply),
      .wrap       (wrap[i]),
      .clken      (clken[i]),
      .outclk     (outclk[i]),
      .pending    (pending[i])
    );
  end

endmodule

// File: tb/tb_spw_clken_divgen.sv
// -----------------------------------------------------------------------------
// tb_spw_clken_divgen
// Self-checking bench for spw_clken_divgen (NUM_CH=5, DIV_W=8, DIV_INIT=9,
// LOCK_CYCLES=16). Cycle k is the k-th rising refclk edge after reset
// release; outputs are sampled on the falling edge and inputs driven there.
// Expected clken pulses (channel, cycle) are queued when a scenario is set
// up and popped as the DUT produces pulses on the monitored channels.
// Scenarios for SPW_CLKGEN_SYNC_UPDATE_EN are selected by the same macro.
// -----------------------------------------------------------------------------
module tb_spw_clken_divgen;

  localparam int NUM_CH = 5;
  localparam int DIV_W  = 8;
  localparam int CH_W   = 3;

  logic              refclk  = 1'b0;
  logic              rst     = 1'b1;
  logic              div_wr  = 1'b0;
  logic [CH_W-1:0]   div_ch  = '0;
  logic [DIV_W-1:0]  div_val = '0;
  logic [NUM_CH-1:0] clken;
  logic [NUM_CH-1:0] outclk;
  logic [NUM_CH-1:0] pending;
  logic              locked;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int ch;
    int cyc;
  } ev_t;

  ev_t               sb_q[$];
  logic [NUM_CH-1:0] sb_mask = '0;

  spw_clken_divgen #(
    .NUM_CH      (NUM_CH),
    .DIV_W       (DIV_W),
    .DIV_INIT    (9),
    .LOCK_CYCLES (16)
  ) dut (
    .refclk  (refclk),
    .rst     (rst),
    .div_wr  (div_wr),
    .div_ch  (div_ch),
    .div_val (div_val),
    .clken   (clken),
    .outclk  (outclk),
    .pending (pending),
    .locked  (locked)
  );

  always #5 refclk = ~refclk;

  always @(posedge refclk) begin
    cyc <= rst ? 0 : cyc + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, limit reached");
    $fatal(1, "watchdog expired");
  end

  // Insert keeping (cycle, channel) order, matching the monitor's scan order.
  function automatic void sb_push(input int ch, input int c);
    int  idx;
    ev_t ev;
    idx = sb_q.size();
    for (int i = 0; i < sb_q.size(); i++) begin
      if (sb_q[i].cyc > c || (sb_q[i].cyc == c && sb_q[i].ch > ch)) begin
        idx = i;
        break;
      end
    end
    ev.ch  = ch;
    ev.cyc = c;
    sb_q.insert(idx, ev);
  endfunction

  function automatic void push_train(input int ch, input int first,
                                     input int period, input int count);
    for (int k = 0; k < count; k++) sb_push(ch, first + k * period);
  endfunction

  task automatic sb_step();
    ev_t ev;
    while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
      ev = sb_q.pop_front();
      checks++;
      errors++;
      $display("FAIL sb_missed: ch%0d no clken seen, expected at cycle %0d (now %0d)",
               ev.ch, ev.cyc, cyc);
    end
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (sb_mask[ch] && clken[ch]) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: ch%0d clken at cycle %0d, none expected", ch, cyc);
        end else begin
          ev = sb_q.pop_front();
          if (ev.ch != ch || ev.cyc != cyc) begin
            errors++;
            $display("FAIL sb_pulse: got ch%0d at cycle %0d, expected ch%0d at cycle %0d",
                     ch, cyc, ev.ch, ev.cyc);
          end
        end
      end
    end
  endtask

  task automatic step();
    @(negedge refclk);
    sb_step();
  endtask

  task automatic wait_cyc(input int target);
    int guard = 0;
    if (cyc > target) begin
      checks++;
      errors++;
      $display("FAIL wait_cyc: already at cycle %0d, wanted %0d", cyc, target);
    end
    while (cyc < target && guard < 2000) begin
      step();
      guard++;
    end
  endtask

  task automatic sb_end(input string tag);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s_leftover: %0d expected pulses never seen, first ch%0d at cycle %0d",
               tag, sb_q.size(), sb_q[0].ch, sb_q[0].cyc);
    end
    sb_q.delete();
    sb_mask = '0;
  endtask

  task automatic do_write(input int ch, input int val);
    div_ch  = CH_W'(ch);
    div_val = DIV_W'(val);
    div_wr  = 1'b1;
    step();
    div_wr  = 1'b0;
  endtask

  task automatic test_reset();
    int bad = 0;
    rst = 1'b1;
    repeat (3) step();
    checks++;
    if ({clken, outclk, pending, locked} !== '0) begin
      errors++;
      $display("FAIL reset_state: clken=%b outclk=%b pending=%b locked=%b, expected all 0",
               clken, outclk, pending, locked);
    end
    rst = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      step();
      if (locked !== 1'b0 || clken !== '0 || outclk !== '0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL prelock_quiet: %0d cycles active before lock, expected 0", bad);
    end
    step();
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL lock_rise: locked=%b at cycle %0d, expected 1", locked, cyc);
    end
    checks++;
    if (clken !== '0 || outclk !== '0) begin
      errors++;
      $display("FAIL lock_cycle_out: clken=%b outclk=%b at lock cycle, expected 0", clken, outclk);
    end
  endtask

  task automatic test_lock_align();
    int h = 0;
    for (int ch = 0; ch < NUM_CH; ch++) push_train(ch, 26, 10, 3);
    sb_mask = '1;
    wait_cyc(36);
    for (int k = 0; k < 10; k++) begin
      step();
      if (k == 0) begin
        checks++;
        if (outclk !== 5'b11111) begin
          errors++;
          $display("FAIL align_outclk: outclk=%b at cycle %0d, expected 11111", outclk, cyc);
        end
      end
      if (outclk[2]) h++;
    end
    checks++;
    if (h != 5) begin
      errors++;
      $display("FAIL d9_duty: outclk high %0d of 10 cycles, expected 5", h);
    end
    wait_cyc(50);
    sb_end("lock_align");
  endtask

  task automatic test_div4();
    int h = 0;
    wait_cyc(50);
    do_write(0, 4);
    checks++;
    if (pending !== 5'b00001) begin
      errors++;
      $display("FAIL div4_pending_set: pending=%b, expected 00001", pending);
    end
    push_train(0, 56, 5, 4);
    sb_mask = 5'b00001;
    wait_cyc(56);
    checks++;
    if (pending !== 5'b00000) begin
      errors++;
      $display("FAIL div4_pending_clr: pending=%b at cycle %0d, expected 00000", pending, cyc);
    end
    for (int k = 0; k < 5; k++) begin
      step();
      if (outclk[0]) h++;
    end
    checks++;
    if (h != 3) begin
      errors++;
      $display("FAIL d4_duty: outclk high %0d of 5 cycles, expected 3", h);
    end
    wait_cyc(73);
    sb_end("div4");
  endtask

  task automatic test_pending_update();
    wait_cyc(80);
    push_train(1, 86, 20, 3);
    sb_mask = 5'b00010;
    do_write(1, 19);
    checks++;
    if (pending !== 5'b00010) begin
      errors++;
      $display("FAIL upd_pending_set: pending=%b, expected 00010", pending);
    end
    wait_cyc(85);
    checks++;
    if (pending !== 5'b00010) begin
      errors++;
      $display("FAIL upd_pending_hold: pending=%b at cycle 85, expected 00010", pending);
    end
    wait_cyc(86);
    checks++;
    if (pending !== 5'b00000 || locked !== 1'b1) begin
      errors++;
      $display("FAIL upd_pending_clr: pending=%b locked=%b at cycle 86, expected 00000/1",
               pending, locked);
    end
    wait_cyc(130);
    sb_end("pending_update");
  endtask

  task automatic test_back_to_back();
    wait_cyc(130);
    sb_push(2, 136); sb_push(2, 144); sb_push(2, 152); sb_push(2, 160);
    sb_push(2, 163); sb_push(2, 166); sb_push(2, 169);
    push_train(3, 136, 10, 4);
    sb_mask = 5'b01100;
    do_write(2, 3);
    do_write(2, 7);
    checks++;
    if (pending !== 5'b00100) begin
      errors++;
      $display("FAIL b2b_pending: pending=%b, expected 00100", pending);
    end
    wait_cyc(140);
    do_write(7, 0);
    checks++;
    if (pending !== 5'b00000) begin
      errors++;
      $display("FAIL bad_ch_ignored: pending=%b after div_ch=7 write, expected 00000", pending);
    end
    wait_cyc(151);
    do_write(2, 2);
    checks++;
    if (pending !== 5'b00100) begin
      errors++;
      $display("FAIL wrap_write_pending: pending=%b at cycle %0d, expected 00100", pending, cyc);
    end
    wait_cyc(160);
    checks++;
    if (pending !== 5'b00000) begin
      errors++;
      $display("FAIL wrap_write_applied: pending=%b at cycle 160, expected 00000", pending);
    end
    wait_cyc(170);
    sb_end("back_to_back");
  endtask

  task automatic test_div0();
    int hc = 0;
    int ho = 0;
    wait_cyc(172);
    do_write(4, 0);
    wait_cyc(177);
    for (int k = 0; k < 10; k++) begin
      step();
      if (clken[4]) hc++;
      if (outclk[4]) ho++;
    end
    checks++;
    if (hc != 10) begin
      errors++;
      $display("FAIL d0_clken: clken high %0d of 10 cycles, expected 10", hc);
    end
    checks++;
    if (ho != 10) begin
      errors++;
      $display("FAIL d0_outclk: outclk high %0d of 10 cycles, expected 10", ho);
    end
  endtask

`ifdef SPW_CLKGEN_SYNC_UPDATE_EN
  task automatic test_sync_update();
    wait_cyc(57);
    push_train(0, 66, 10, 4);
    sb_push(1, 66); sb_push(1, 73); sb_push(1, 80); sb_push(1, 93); sb_push(1, 100);
    sb_push(3, 66); sb_push(3, 81); sb_push(3, 101);
    sb_mask = 5'b01011;
    do_write(1, 6);
    do_write(3, 14);
    checks++;
    if (pending !== 5'b01010) begin
      errors++;
      $display("FAIL sync_pending_set: pending=%b, expected 01010", pending);
    end
    wait_cyc(66);
    checks++;
    if (pending !== 5'b00000) begin
      errors++;
      $display("FAIL sync_pending_clr: pending=%b at cycle 66, expected 00000", pending);
    end
    wait_cyc(78);
    do_write(2, 9);
    wait_cyc(86);
    checks++;
    if (clken !== 5'b10101 || pending !== 5'b00000) begin
      errors++;
      $display("FAIL sync_realign: clken=%b pending=%b at cycle 86, expected 10101/00000",
               clken, pending);
    end
    wait_cyc(104);
    sb_end("sync_update");
  endtask
`endif

  task automatic test_mid_reset();
    do_write(3, 5);
    checks++;
    if (pending !== 5'b01000) begin
      errors++;
      $display("FAIL mrst_pending: pending=%b before reset, expected 01000", pending);
    end
    step();
    rst = 1'b1;
    step();
    checks++;
    if ({clken, outclk, pending, locked} !== '0) begin
      errors++;
      $display("FAIL mrst_outputs: clken=%b outclk=%b pending=%b locked=%b, expected all 0",
               clken, outclk, pending, locked);
    end
    rst = 1'b0;
    wait_cyc(15);
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("FAIL mrst_lock_early: locked=%b at cycle 15, expected 0", locked);
    end
    step();
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL mrst_lock: locked=%b at cycle 16, expected 1", locked);
    end
    for (int ch = 0; ch < NUM_CH; ch++) push_train(ch, 26, 10, 3);
    sb_mask = '1;
    wait_cyc(50);
    sb_end("mid_reset");
  endtask

  initial begin
    test_reset();
    test_lock_align();
`ifdef SPW_CLKGEN_SYNC_UPDATE_EN
    test_sync_update();
`else
    test_div4();
    test_pending_update();
    test_back_to_back();
    test_div0();
`endif
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spw_clken_divgen.md
SPW_CLKEN_DIVGEN -- requirements
Module: spw_clken_divgen

Interface
REQ-001 SHALL have parameter NUM_CH, default 5, number of output channels (1..16).
REQ-002 SHALL have parameter DIV_W, default 8, divisor field width.
REQ-003 SHALL have parameter DIV_INIT, default 9, reset divisor loaded into every channel.
REQ-004 SHALL have parameter LOCK_CYCLES, default 16, cycles after reset before lock.
REQ-005 SHALL have port refclk, input, 1, sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port div_wr, input, 1, single-cycle divisor write strobe.
REQ-008 SHALL have port div_ch, input, $clog2(NUM_CH) (min 1), target channel of write.
REQ-009 SHALL have port div_val, input, DIV_W, new divisor D.
REQ-010 SHALL have port clken, output, NUM_CH, per-channel one-cycle enable pulse.
REQ-011 SHALL have port outclk, output, NUM_CH, per-channel registered divided clock.
REQ-012 SHALL have port pending, output, NUM_CH, divisor update waiting to be applied.
REQ-013 SHALL have port locked, output, 1, outputs valid.

Function
REQ-014 Channel period SHALL be P = D+1 refclk cycles; D=0 gives clken held high every cycle.
REQ-015 Each channel counter SHALL count 0..D, wrapping to 0; clken[i] SHALL be high exactly in the cycle counter equals D.
REQ-016 outclk[i] SHALL be high while counter < ceil(P/2), else low; for D=0 held high.
REQ-017 clken/outclk SHALL be registered (one cycle after counter state) and forced 0 while locked=0.
REQ-018 Lock counter SHALL count refclk cycles from reset release; locked SHALL rise in cycle LOCK_CYCLES and stay high until rst.
REQ-019 Channel counters SHALL be held at 0 until locked, so all channels start phase-aligned at lock.
REQ-020 div_wr SHALL capture div_val into channel div_ch's shadow register and set pending[div_ch] next cycle.
REQ-021 Shadow SHALL be transferred to active divisor in the cycle the channel counter wraps (counter==D); pending cleared same cycle; no truncated or stretched period.
REQ-022 Write while pending SHALL overwrite the shadow (last write wins), pending stays high.
REQ-023 Write coincident with wrap SHALL NOT apply in that wrap; applied at the following wrap.
REQ-024 div_wr with div_ch >= NUM_CH SHALL be ignored.
REQ-025 Writes while locked=0 SHALL be applied at the first wrap after lock.
REQ-026 Divisor updates SHALL NOT affect locked.

Reset
REQ-027 On rst: counters 0, active and shadow divisors DIV_INIT, pending 0, clken 0, outclk 0, lock counter 0, locked 0.
REQ-028 rst mid-operation SHALL discard pending updates and restart the lock sequence.

Configuration
REQ-029 Macro SPW_CLKGEN_SYNC_UPDATE_EN: defined -> all pending updates applied simultaneously at channel 0 wrap, and every channel counter reloads to 0 then (re-phase-align); undefined -> each channel applies at its own wrap per REQ-021.

Structure
REQ-030 Package spw_clkgen_pkg SHALL hold default parameter constants and the max channel count.
REQ-031 Per-channel counter/shadow/output logic SHALL be sub-module spw_clkgen_ch, instantiated NUM_CH times by generate.

Verification
REQ-032 Reset, LOCK_CYCLES=16 -> locked rises cycle 16; clken/outclk 0 before; all channels' first clken at cycle 16+10 (D=9).
REQ-033 D=9 steady state -> clken every 10 cycles; outclk 5 high/5 low; D=4 -> 3 high/2 low.
REQ-034 Write ch1 D=19 mid-period -> pending[1]=1, current 10-cycle period completes, next period 20 cycles, pending cleared at wrap.
REQ-035 Two writes ch2 (D=3 then D=7) before wrap -> only D=7 applied; write on wrap cycle -> applied one period later; div_ch=7 with NUM_CH=5 -> no change.
REQ-036 D=0 -> clken constant 1, outclk constant 1; rst asserted mid-run -> all outputs 0 next cycle, divisors back to 9.
REQ-037 SPW_CLKGEN_SYNC_UPDATE_EN defined, writes ch1 and ch3 -> both applied at ch0 wrap, all clken realigned.
